bldc_commutator: RTL
====================

# bldc_commutator

Parametrised six-step sensorless BLDC commutation engine for the XLR8 ESC path, sitting between the CPU-written duty register and the three half-bridge drivers (IN/SD pairs). It runs an open-loop startup ramp, hands over to closed-loop commutation on filtered back-EMF comparator edges, detects stalls by timeout and, optionally, measures electrical period. Widths, ramp profile, filter length and timeouts are parameters.

## Interface
- PWM_W, 8, duty/PWM counter width
- TICK_DIV, 16, clk cycles per timing tick (1 µs at 16 MHz)
- FILT_LEN, 16, clk cycles a feedback level must be stable to be accepted (≥2)
- START_PERIOD, 5000, initial open-loop step period in ticks
- MIN_PERIOD, 1000, open-loop period at which RUN is entered
- RAMP_STEP, 5, ticks subtracted from step period after each open-loop step
- START_DUTY, 40, duty used during RAMP
- TIMEOUT, 20000, ticks without expected edge in RUN before stall
- PER_W, 24, period measurement width
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- enable  in  1  level; 1 = spin motor
- duty  in  PWM_W  CPU duty value
- duty_vld  in  1  1-cycle strobe capturing duty
- fb  in  3  raw comparator outputs, phases 1..3 (asynchronous)
- in_hi  out  3  driver IN per phase (1 = source)
- sd  out  3  driver SD per phase (1 = enabled)
- step_idx  out  3  current commutation step 0..5
- running  out  1  1 in RUN
- stall  out  1  sticky stall flag
- period  out  PER_W  last electrical period in clk cycles
- period_vld  out  1  1-cycle strobe on period update

## Operation
- FSM: IDLE, RAMP, RUN, STALL. Reset → IDLE, step 0.
- IDLE: all sd/in_hi 0. enable=1 → RAMP, step 0, step period = START_PERIOD.
- RAMP: duty_eff = START_DUTY; step advances (5→0 wrap) each time step period elapses; after each step, period −= RAMP_STEP, floored at MIN_PERIOD. First step completed at MIN_PERIOD → RUN, wait counter cleared.
- RUN: duty_eff = duty register. Advance step on any edge (either polarity) of the expected filtered phase: steps 0/3 → fb[2], 1/4 → fb[1], 2/5 → fb[0]. Edges on other phases ignored. No expected edge for TIMEOUT ticks → STALL.
- STALL: outputs off, stall=1; remains until enable=0, then IDLE (stall clears on IDLE entry).
- enable=0 in any state → IDLE next cycle.
- Drive table (source/sink): 0:1/2, 1:1/3, 2:2/3, 3:2/1, 4:3/1, 5:3/2. Source: in_hi=1, sd=pwm_on. Sink: in_hi=0, sd=1. Float: both 0.
- PWM: free-running PWM_W counter; pwm_on = cnt < duty_latched. duty_latched loads duty_eff only on counter wrap (cnt all-ones). duty=0 → never on; all-ones → on 2^PWM_W−1 of 2^PWM_W cycles.
- duty register: loads on duty_vld; reset 0.

## Timing
- Reset values: sd=0, in_hi=0, step_idx=0, running=0, stall=0, period=0, period_vld=0; asynchronous.
- fb: 2-flop synchroniser, then filter; accepted-level latency = 2 + FILT_LEN cycles.
- Expected edge → step_idx change 1 cycle later; sd/in_hi follow the new step on the same cycle (registered from next-state).
- duty_vld on wrap cycle: applied at the following wrap (old value latched).
- Tick counter free-runs from reset; ramp/timeout granularity ±1 tick.
- Expected edge and timeout on same cycle: edge wins.

## Configuration
- BLDC_COMM_PERIOD_EN defined: in RUN, count clk cycles between successive step 5→0 transitions, saturating at all-ones; on each transition period ← count, period_vld pulses 1 cycle, counter restarts. Counter cleared outside RUN; first 5→0 after RUN entry only restarts it (no strobe).
- Undefined: period=0, period_vld=0 constantly; no counter logic.

## Structure
- bldc_comm_pkg: FSM state enum, step-to-(source,sink) table constants, expected-phase lookup.
- Sub-module bldc_fb_filter (one instance per phase): synchroniser plus FILT_LEN stability counter, outputs filtered level.

## Test plan
- Reset with enable=1, release → RAMP, step advances after 5000 ticks, then 4995, 4990…; RUN entered when period reaches 1000; running=1.
- RUN, step 0, toggle fb[1] then fb[2] → only fb[2] advances to step 1; sd=3'b101, in_hi=3'b001.
- duty_vld with duty=128 mid-period → sd[source] high exactly 128 of 256 cycles, starting at next wrap.
- fb glitch of FILT_LEN−1 cycles on expected phase → no step change; FILT_LEN cycles → advance.
- RUN with fb static for 20000 ticks → stall=1, all outputs 0; enable=0 → IDLE, stall=0.
- With BLDC_COMM_PERIOD_EN: edges every 1000 clk cycles → period=6000 with period_vld 1-cycle pulse per revolution.

Source files
------------

// File: rtl/bldc_comm_pkg.sv
// Shared types and commutation tables for the six-step BLDC commutator.
// Phase indices 0..2 correspond to motor phases 1..3.
package bldc_comm_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RAMP,
      ST_RUN,
      ST_STALL
   } state_e;

   // Source (high-side) phase of each step as a one-hot mask.
   function automatic logic [2:0] src_mask(input logic [2:0] step);
      case (step)
         3'd0, 3'd1: src_mask = 3'b001;
         3'd2, 3'd3: src_mask = 3'b010;
         3'd4, 3'd5: src_mask = 3'b100;
         default:    src_mask = 3'b000;
      endcase
   endfunction

   function automatic logic [2:0] snk_mask(input logic [2:0] step);
      case (step)
         3'd0, 3'd5: snk_mask = 3'b010;
         3'd1, 3'd2: snk_mask = 3'b100;
         3'd3, 3'd4: snk_mask = 3'b001;
         default:    snk_mask = 3'b000;
      endcase
   endfunction

   // The floating phase carries the back-EMF zero crossing we wait for.
   function automatic logic [1:0] exp_phase(input logic [2:0] step);
      case (step)
         3'd0, 3'd3: exp_phase = 2'd2;
         3'd1, 3'd4: exp_phase = 2'd1;
         default:    exp_phase = 2'd0;
      endcase
   endfunction

   function automatic logic [2:0] next_step(input logic [2:0] step);
      next_step = (step == 3'd5) ? 3'd0 : step + 3'd1;
   endfunction

endpackage

// File: rtl/bldc_fb_filter.sv
// Back-EMF comparator conditioning: 2-flop synchroniser followed by a
// stability filter that accepts a new level after FILT_LEN steady cycles.
module bldc_fb_filter #(
   parameter int FILT_LEN = 16
) (
   input  logic clk,
   input  logic reset_n,
   input  logic fb_i,
   output logic filt_o
);
   localparam int CW = $clog2(FILT_LEN);

   logic          s1_q, s2_q;
   logic          filt_q, filt_d;
   logic [CW-1:0] cnt_q, cnt_d;

   always_comb begin
      filt_d = filt_q;
      cnt_d  = '0;
      if (s2_q != filt_q) begin
         if (cnt_q == CW'(FILT_LEN - 1)) filt_d = s2_q;
         else                            cnt_d  = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         s1_q   <= 1'b0;
         s2_q   <= 1'b0;
         filt_q <= 1'b0;
         cnt_q  <= '0;
      end else begin
         s1_q   <= fb_i;
         s2_q   <= s1_q;
         filt_q <= filt_d;
         cnt_q  <= cnt_d;
      end
   end

   assign filt_o = filt_q;

endmodule

// File: rtl/bldc_commutator.sv
// Six-step sensorless BLDC commutator: open-loop ramp, back-EMF closed loop,
// stall timeout. Define BLDC_COMM_PERIOD_EN to enable electrical-period measurement.
module bldc_commutator
   import bldc_comm_pkg::*;
#(
   parameter int PWM_W        = 8,
   parameter int TICK_DIV     = 16,
   parameter int FILT_LEN     = 16,
   parameter int START_PERIOD = 5000,
   parameter int MIN_PERIOD   = 1000,
   parameter int RAMP_STEP    = 5,
   parameter int START_DUTY   = 40,
   parameter int TIMEOUT      = 20000,
   parameter int PER_W        = 24
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             enable,
   input  logic [PWM_W-1:0] duty,
   input  logic             duty_vld,
   input  logic [2:0]       fb,
   output logic [2:0]       in_hi,
   output logic [2:0]       sd,
   output logic [2:0]       step_idx,
   output logic             running,
   output logic             stall,
   output logic [PER_W-1:0] period,
   output logic             period_vld
);
   localparam int TW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int WMAX = (TIMEOUT > START_PERIOD) ? TIMEOUT : START_PERIOD;
   localparam int WW   = $clog2(WMAX + 1);

   state_e           state_q, state_d;
   logic [2:0]       step_q, step_d;
   logic [WW-1:0]    per_q, per_d, wait_q, wait_d;
   logic [TW-1:0]    tick_q;
   logic             tick;
   logic [2:0]       filt, filt_prev_q, filt_edge;
   logic [1:0]       eph;
   logic             exp_edge;
   logic [PWM_W-1:0] duty_q, duty_eff, duty_lat_q, duty_lat_d, pwm_cnt_q, pwm_cnt_d;
   logic             pwm_on_d, drv_on;
   logic [2:0]       src_m, snk_m, in_hi_q, in_hi_d, sd_q, sd_d;

   for (genvar g = 0; g < 3; g++) begin : g_fb
      bldc_fb_filter #(.FILT_LEN(FILT_LEN)) u_filt (
         .clk    (clk),
         .reset_n(reset_n),
         .fb_i   (fb[g]),
         .filt_o (filt[g])
      );
   end

   assign tick      = (tick_q == TW'(TICK_DIV - 1));
   assign filt_edge = filt ^ filt_prev_q;
   assign eph       = exp_phase(step_q);
   assign exp_edge  = filt_edge[eph];

   always_comb begin
      state_d = state_q;
      step_d  = step_q;
      per_d   = per_q;
      wait_d  = wait_q;
      case (state_q)
         ST_IDLE: begin
            step_d = '0;
            wait_d = '0;
            per_d  = WW'(START_PERIOD);
            if (enable) state_d = ST_RAMP;
         end
         ST_RAMP: begin
            if (tick) begin
               if ((wait_q + 1'b1) >= per_q) begin
                  step_d = next_step(step_q);
                  wait_d = '0;
                  if (per_q <= WW'(MIN_PERIOD))                  state_d = ST_RUN;
                  else if (per_q > WW'(MIN_PERIOD + RAMP_STEP)) per_d   = per_q - WW'(RAMP_STEP);
                  else                                           per_d   = WW'(MIN_PERIOD);
               end else begin
                  wait_d = wait_q + 1'b1;
               end
            end
         end
         ST_RUN: begin
            // An accepted edge beats a timeout landing on the same cycle.
            if (exp_edge) begin
               step_d = next_step(step_q);
               wait_d = '0;
            end else if (tick) begin
               if ((wait_q + 1'b1) >= WW'(TIMEOUT)) state_d = ST_STALL;
               else                                 wait_d  = wait_q + 1'b1;
            end
         end
         default: ;
      endcase
      if (!enable) state_d = ST_IDLE;
   end

   // Drive outputs are registered from next-state so they switch with step_idx.
   always_comb begin
      pwm_cnt_d  = pwm_cnt_q + 1'b1;
      duty_eff   = (state_q == ST_RAMP) ? PWM_W'(START_DUTY) : duty_q;
      duty_lat_d = (&pwm_cnt_q) ? duty_eff : duty_lat_q;
      pwm_on_d   = (pwm_cnt_d < duty_lat_d);
      src_m      = src_mask(step_d);
      snk_m      = snk_mask(step_d);
      drv_on     = (state_d == ST_RAMP) || (state_d == ST_RUN);
      in_hi_d    = drv_on ? src_m : 3'b000;
      sd_d       = drv_on ? (snk_m | (pwm_on_d ? src_m : 3'b000)) : 3'b000;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= ST_IDLE;
         step_q      <= '0;
         per_q       <= WW'(START_PERIOD);
         wait_q      <= '0;
         tick_q      <= '0;
         filt_prev_q <= '0;
         duty_q      <= '0;
         duty_lat_q  <= '0;
         pwm_cnt_q   <= '0;
         in_hi_q     <= '0;
         sd_q        <= '0;
      end else begin
         state_q     <= state_d;
         step_q      <= step_d;
         per_q       <= per_d;
         wait_q      <= wait_d;
         tick_q      <= tick ? '0 : tick_q + 1'b1;
         filt_prev_q <= filt;
         if (duty_vld) duty_q <= duty;
         duty_lat_q  <= duty_lat_d;
         pwm_cnt_q   <= pwm_cnt_d;
         in_hi_q     <= in_hi_d;
         sd_q        <= sd_d;
      end
   end

   assign in_hi    = in_hi_q;
   assign sd       = sd_q;
   assign step_idx = step_q;
   assign running  = (state_q == ST_RUN);
   assign stall    = (state_q == ST_STALL);

`ifdef BLDC_COMM_PERIOD_EN
   logic [PER_W-1:0] pcnt_q, pcnt_d, period_q, period_d;
   logic             pvld_q, pvld_d, armed_q, armed_d, wrap5;

   assign wrap5 = (state_q == ST_RUN) && (step_q == 3'd5) && (step_d == 3'd0);

   // First revolution after RUN entry only arms the measurement.
   always_comb begin
      period_d = period_q;
      pvld_d   = 1'b0;
      armed_d  = armed_q;
      pcnt_d   = (&pcnt_q) ? pcnt_q : pcnt_q + 1'b1;
      if (state_q != ST_RUN) begin
         pcnt_d  = '0;
         armed_d = 1'b0;
      end else if (wrap5) begin
         pcnt_d  = PER_W'(1);
         armed_d = 1'b1;
         if (armed_q) begin
            period_d = pcnt_q;
            pvld_d   = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pcnt_q   <= '0;
         period_q <= '0;
         pvld_q   <= 1'b0;
         armed_q  <= 1'b0;
      end else begin
         pcnt_q   <= pcnt_d;
         period_q <= period_d;
         pvld_q   <= pvld_d;
         armed_q  <= armed_d;
      end
   end

   assign period     = period_q;
   assign period_vld = pvld_q;
`else
   assign period     = '0;
   assign period_vld = 1'b0;
`endif

endmodule
